comm_transmitter: RTL and testbench
===================================

Name: comm_transmitter

Overview:
Host-side transmitter for the 6-bit chunked command link. It accepts one 32-bit command packet {X[7:0], Y[7:0], data[15:0]} through a valid/ready handshake. It serializes the packet MSB-first onto the narrow port, then sends one all-zero terminator chunk. Each chunk gets a timed strobe, slow enough to pass the far-end debouncer, which uses the strobe as its receive clock.

Parameters:
CHUNK_W, 6, width of the port in bits
PKT_W, 32, packet width in bits
SETUP, 2, cycles the port is stable with strobe low before each rising edge (min 1)
HIGH, 4, cycles strobe is held high per chunk (min 1)
HOLD, 2, cycles strobe is held low after the falling edge, before the port may change (min 1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  packet offered
in_ready  out  1  block idle and able to accept a packet
in_pkt  in  PKT_W  packet, laid out {X, Y, dataOut}
port  out  CHUNK_W  chunk presented to the link
strobe  out  1  chunk strobe; the far end samples port on its debounced rising edge
busy  out  1  a packet is in flight
done  out  1  one-cycle pulse when the terminator slot completes

Behaviour:
- Derived constants:
  - N_DATA = PKT_W/CHUNK_W + 1, which is 6 at the defaults.
  - N_CHUNKS = N_DATA + 1, which is 7.
  - T = SETUP + HIGH + HOLD, which is 8 cycles per chunk.
- Shift register: in_pkt is zero-extended to N_DATA*CHUNK_W bits (36 at the defaults). Chunk k (k = 0..N_DATA-1) is the slice starting from the MSB end. Chunk N_DATA is always 0 (the terminator).
- Reset values:
  - port = 0, strobe = 0, busy = 0, done = 0.
  - in_ready = 1; its value is ignored while reset is high.
  - FSM = IDLE, chunk index = 0, phase counter = 0.
- FSM states: IDLE, SETUP_PH, HIGH_PH, HOLD_PH.
  - IDLE: in_ready = 1. On in_valid && in_ready at edge E0:
    - latch the packet;
    - port <= chunk0;
    - in_ready <= 0, busy <= 1;
    - go to SETUP_PH.
  - SETUP_PH, SETUP cycles: strobe = 0, port stable. Then strobe <= 1 and go to HIGH_PH. Strobe rises at E0+SETUP.
  - HIGH_PH, HIGH cycles: strobe = 1, port stable. Then strobe <= 0 and go to HOLD_PH.
  - HOLD_PH, HOLD cycles: strobe = 0, port stable. At the end of the slot:
    - if the index is below N_CHUNKS-1: index++, port <= next chunk, go to SETUP_PH;
    - otherwise: port <= 0, busy <= 0, in_ready <= 1, done <= 1 for one cycle, go to IDLE.
- Timing:
  - Slot k spans edges E0+k*T to E0+(k+1)*T.
  - done is high during the cycle after edge E0+N_CHUNKS*T (E0+56 at the defaults).
  - The next accept is possible at E0+N_CHUNKS*T+1, so the minimum packet spacing is N_CHUNKS*T+1 cycles.
- port changes only at slot boundaries, i.e. with strobe low and at least HOLD cycles after the last falling edge. It never changes while strobe is high.
- in_valid or in_pkt changes while busy are ignored. The latched packet is unaffected.
- Reset mid-packet: the next edge forces the reset values, and the partial packet is dropped. The far end is expected to be reset in parallel.
- Exactly N_CHUNKS rising strobe edges occur per packet. No strobe activity occurs in IDLE.

Decomposition:
- Shared package comm_pkg holds CHUNK_W, PKT_W, N_DATA, N_CHUNKS, the FSM state enum, and field offsets for X, Y and data. The receiver and interpreter reuse these constants.
- One sub-module, comm_strobe_gen, owns the phase counter and the SETUP/HIGH/HOLD sequencing. It takes a start pulse and returns a slot_end pulse and strobe. comm_transmitter owns the handshake, shift register and chunk index.

Test Plan:
- Accept 0xA53C1234 (X=A5, Y=3C, data=1234) -> port sequence 0x02, 0x25, 0x0F, 0x01, 0x08, 0x34, 0x00. Each value is present at its strobe rise. Strobe rises at E0+2, 10, ..., 50. done is high during the cycle after E0+56.
- Accept 0xFFFFFFFF -> chunks 0x03, 0x3F, 0x3F, 0x3F, 0x3F, 0x3F, 0x00. Exactly 7 rising edges occur. port never changes while strobe = 1 (assertion).
- Hold in_valid high with two packets back-to-back -> the second is accepted at E0+57. in_pkt changes during busy have no effect on the first packet's chunks.
- Loopback through the debounce + comm_receiver model, 100 random packets -> each is received intact with write asserted once per packet, and X/Y/dataOut match.
- Assert reset during HIGH_PH of chunk 3 -> the next cycle shows strobe = 0, port = 0, busy = 0, in_ready = 1. A fresh packet afterwards is sent correctly from chunk 0.
- SETUP=1, HIGH=1, HOLD=1 -> T = 3, done is high during the cycle after E0+21, and the chunk values are identical to the first scenario.

Source files
------------

// File: rtl/comm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : comm_pkg
// Description : Shared constants and types for the 6-bit chunked command link.
//               The transmitter, receiver and interpreter use these constants.
//               Packet layout is {X[7:0], Y[7:0], data[15:0]}. It is
//               zero-extended to N_DATA chunks and sent MSB-first. An all-zero
//               terminator chunk follows the data chunks.
// Revision    : 1.0 - initial release
// ============================================================================
package comm_pkg;

    localparam int CHUNK_W  = 6;
    localparam int PKT_W    = 32;
    localparam int N_DATA   = PKT_W / CHUNK_W + 1;   // data chunks per packet
    localparam int N_CHUNKS = N_DATA + 1;            // data chunks + terminator
    localparam int SHIFT_W  = N_DATA * CHUNK_W;      // zero-extended packet width

    // Field offsets inside a packet
    localparam int X_LSB    = 24;
    localparam int X_W      = 8;
    localparam int Y_LSB    = 16;
    localparam int Y_W      = 8;
    localparam int DATA_LSB = 0;
    localparam int DATA_W   = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP_PH = 2'd1,
        HIGH_PH  = 2'd2,
        HOLD_PH  = 2'd3
    } tx_state_e;

    // Left-pad the packet with zeros so that it splits into whole chunks.
    function automatic logic [SHIFT_W-1:0] extend_pkt(input logic [PKT_W-1:0] pkt);
        return {{(SHIFT_W - PKT_W){1'b0}}, pkt};
    endfunction

endpackage
`default_nettype wire

// File: rtl/comm_strobe_gen.sv
`default_nettype none
// ============================================================================
// Module      : comm_strobe_gen
// Description : Timing engine for one chunk slot. A start pulse begins a slot.
//               The slot holds strobe low for SETUP cycles, high for HIGH
//               cycles, and low again for HOLD cycles. slot_end is high in the
//               last HOLD cycle. If start is high in that same cycle, the next
//               slot follows with no gap.
// Ports       : clk, reset (sync, active-high)
//               start    - begin a slot (taken in IDLE or at slot_end)
//               slot_end - combinational, last cycle of the current slot
//               strobe   - registered chunk strobe
// Revision    : 1.0 - initial release
// ============================================================================
module comm_strobe_gen
    import comm_pkg::*;
#(
    parameter int SETUP = 2,
    parameter int HIGH  = 4,
    parameter int HOLD  = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic slot_end,
    output logic strobe
);

    localparam int MAX_LEN = (SETUP > HIGH) ? ((SETUP > HOLD) ? SETUP : HOLD)
                                            : ((HIGH  > HOLD) ? HIGH  : HOLD);
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP - 1);
    localparam logic [CNT_W-1:0] HIGH_LAST  = CNT_W'(HIGH - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD - 1);

    tx_state_e        state;
    tx_state_e        state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // slot_end depends only on registered state. The top can therefore build
    // start from it without creating a combinational loop.
    assign slot_end = (state == HOLD_PH) && (cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            strobe <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            // Register the strobe from the next state so that the output
            // never glitches on a state decode.
            strobe <= (state_next == HIGH_PH);
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + CNT_W'(1);
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (start) begin
                    state_next = SETUP_PH;
                end
            end
            SETUP_PH: begin
                if (cnt == SETUP_LAST) begin
                    state_next = HIGH_PH;
                    cnt_next   = '0;
                end
            end
            HIGH_PH: begin
                if (cnt == HIGH_LAST) begin
                    state_next = HOLD_PH;
                    cnt_next   = '0;
                end
            end
            HOLD_PH: begin
                if (cnt == HOLD_LAST) begin
                    cnt_next   = '0;
                    state_next = start ? SETUP_PH : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/comm_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : comm_transmitter
// Description : Host-side transmitter for the 6-bit chunked command link.
//               It accepts one packet through a valid/ready handshake and
//               sends it MSB-first as N_DATA chunks, then one zero
//               terminator chunk. Every chunk gets one strobe pulse from
//               comm_strobe_gen.
// Ports       : clk, reset (sync, active-high)
//               in_valid/in_ready/in_pkt - packet handshake
//               port   - chunk on the link; changes only at slot boundaries
//               strobe - chunk strobe (far end samples on its rising edge)
//               busy   - a packet is in flight
//               done   - one-cycle pulse after the terminator slot ends
// Revision    : 1.0 - initial release
// ============================================================================
module comm_transmitter
    import comm_pkg::*;
#(
    parameter int SETUP = 2,
    parameter int HIGH  = 4,
    parameter int HOLD  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PKT_W-1:0]   in_pkt,
    output logic [CHUNK_W-1:0] port,
    output logic               strobe,
    output logic               busy,
    output logic               done
);

    localparam int               IDX_W    = $clog2(N_CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

    logic [SHIFT_W-1:0] shreg;
    logic [SHIFT_W-1:0] pkt_ext;
    logic [IDX_W-1:0]   idx;
    logic               accept;
    logic               slot_end;
    logic               last_slot;
    logic               start;

    assign pkt_ext   = extend_pkt(in_pkt);
    assign accept    = in_valid && in_ready;
    assign last_slot = slot_end && (idx == LAST_IDX);
    // A new slot starts when a packet is accepted or a non-final slot ends.
    assign start     = accept || (slot_end && (idx != LAST_IDX));

    comm_strobe_gen #(
        .SETUP (SETUP),
        .HIGH  (HIGH),
        .HOLD  (HOLD)
    ) u_strobe_gen (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .slot_end (slot_end),
        .strobe   (strobe)
    );

    // shreg holds the chunks that are not yet on port, MSB-aligned. Zeros
    // shift in from the bottom, so the chunk after the last data chunk is
    // always the zero terminator.
    always_ff @(posedge clk) begin
        if (reset) begin
            port     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            in_ready <= 1'b1;
            idx      <= '0;
            shreg    <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                port     <= pkt_ext[SHIFT_W-1 -: CHUNK_W];
                shreg    <= pkt_ext << CHUNK_W;
                idx      <= '0;
                busy     <= 1'b1;
                in_ready <= 1'b0;
            end else if (last_slot) begin
                port     <= '0;
                idx      <= '0;
                busy     <= 1'b0;
                in_ready <= 1'b1;
                done     <= 1'b1;
            end else if (slot_end) begin
                port  <= shreg[SHIFT_W-1 -: CHUNK_W];
                shreg <= shreg << CHUNK_W;
                idx   <= idx + IDX_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_comm_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_comm_transmitter
// Description : Scoreboard bench for comm_transmitter. The drivers push the
//               expected chunk/rise-cycle pairs, done cycles and packets into
//               queues. A monitor pops and compares them on every strobe
//               rise and done pulse. The monitor also rebuilds each packet
//               from the chunks it sees. A second instance with 1/1/1 timing
//               is checked directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comm_transmitter;
    import comm_pkg::*;

    localparam int TB_SETUP = 2;
    localparam int TB_T     = 8;

    typedef logic [5:0] chunks_t [7];
    typedef struct {
        logic [5:0] chunk;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pkt;
    logic [5:0]  port;
    logic        strobe;
    logic        busy;
    logic        done;

    logic        f_valid;
    logic        f_ready;
    logic [31:0] f_pkt;
    logic [5:0]  f_port;
    logic        f_strobe;
    logic        f_busy;
    logic        f_done;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    exp_t        exp_q[$];
    int          done_q[$];
    logic [31:0] pkt_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    comm_transmitter dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pkt   (in_pkt),
        .port     (port),
        .strobe   (strobe),
        .busy     (busy),
        .done     (done)
    );

    comm_transmitter #(.SETUP(1), .HIGH(1), .HOLD(1)) dut_fast (
        .clk      (clk),
        .reset    (reset),
        .in_valid (f_valid),
        .in_ready (f_ready),
        .in_pkt   (f_pkt),
        .port     (f_port),
        .strobe   (f_strobe),
        .busy     (f_busy),
        .done     (f_done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    function automatic chunks_t chunks_of(input logic [31:0] p);
        chunks_t     r;
        logic [35:0] e;
        e = {4'b0, p};
        for (int k = 0; k < 6; k++) begin
            for (int b = 0; b < 6; b++) r[k][5-b] = e[35 - 6*k - b];
        end
        r[6] = 6'h00;
        return r;
    endfunction

    // Call at a negedge. The task offers pkt, waits for in_ready, and queues
    // the expectations once the accept edge is known.
    task automatic offer(input logic [31:0] pkt, input chunks_t ch, input bit keep, output int e0);
        int b;
        b = 0;
        in_valid = 1'b1;
        in_pkt   = pkt;
        while (!in_ready && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (b >= 200) begin
            fail_now("accept_timeout", "in_ready never rose");
            e0 = -1;
        end else begin
            e0 = cyc + 1;
            for (int k = 0; k < 7; k++) exp_q.push_back('{chunk: ch[k], cyc: e0 + k*TB_T + TB_SETUP});
            done_q.push_back(e0 + 7*TB_T);
            pkt_q.push_back(pkt);
        end
        @(negedge clk);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0 || pkt_q.size() != 0) && b < 300) begin
            @(negedge clk);
            b++;
        end
        if (b >= 300) begin
            fail_now("wait_idle_timeout", "expected strobes or done never arrived");
            exp_q.delete(); done_q.delete(); pkt_q.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: compares chunks at strobe rises and rebuilds packets.
    initial begin
        logic        prev_s;
        logic [5:0]  prev_p;
        logic [35:0] rx;
        int          rx_n;
        exp_t        e;
        logic [31:0] ep;
        prev_s = 1'b0; prev_p = '0; rx = '0; rx_n = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_s = 1'b0; rx = '0; rx_n = 0;
            end else begin
                if (strobe && !prev_s) begin
                    if (exp_q.size() == 0) fail_now("unexpected_strobe", "rise with nothing expected");
                    else begin
                        e = exp_q.pop_front();
                        check("chunk_value", port, e.chunk);
                        check("strobe_rise_cycle", cyc, e.cyc);
                    end
                    if (rx_n < N_DATA) begin
                        rx = {rx[29:0], port};
                        rx_n++;
                    end else begin
                        check("terminator_zero", port, 0);
                        if (pkt_q.size() == 0) fail_now("unexpected_packet", "packet with nothing expected");
                        else begin
                            ep = pkt_q.pop_front();
                            check("rx_packet", rx, {4'b0, ep});
                        end
                        rx = '0; rx_n = 0;
                    end
                end
                if (strobe && prev_s) check("port_stable_while_high", port, prev_p);
                if (done) begin
                    if (done_q.size() == 0) fail_now("unexpected_done", "done with nothing expected");
                    else check("done_cycle", cyc, done_q.pop_front());
                end
                prev_s = strobe;
                prev_p = port;
            end
        end
    end

    initial begin
        chunks_t     tbl;
        chunks_t     tbl2;
        int          e0;
        int          e1;
        int          fe0;
        int          fdone;
        int          fn;
        logic        fprev;
        logic [5:0]  fgot [7];
        logic [31:0] rp;

        reset = 1'b1; in_valid = 1'b0; in_pkt = '0;
        f_valid = 1'b0; f_pkt = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_port", port, 0);
        check("reset_strobe", strobe, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_in_ready", in_ready, 1);
        @(negedge clk);

        // Basic packet
        tbl = '{6'h02, 6'h25, 6'h0F, 6'h01, 6'h08, 6'h34, 6'h00};
        offer(32'hA53C1234, tbl, 1'b0, e0);
        check("busy_after_accept", busy, 1);
        check("in_ready_after_accept", in_ready, 0);
        wait_idle();

        // All-ones packet
        tbl = '{6'h03, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h00};
        offer(32'hFFFFFFFF, tbl, 1'b0, e0);
        wait_idle();

        // Back-to-back with in_valid held; in_pkt changes while busy
        tbl  = '{6'h00, 6'h12, 6'h0D, 6'h05, 6'h19, 6'h38, 6'h00};
        tbl2 = '{6'h00, 6'h0F, 6'h03, 6'h30, 6'h03, 6'h3F, 6'h00};
        offer(32'h12345678, tbl, 1'b1, e0);
        offer(32'h0F0F00FF, tbl2, 1'b0, e1);
        check("b2b_accept_spacing", e1 - e0, 57);
        wait_idle();

        // Reset during HIGH_PH of chunk 3
        tbl = '{6'h02, 6'h00, 6'h00, 6'h00, 6'h00, 6'h01, 6'h00};
        offer(32'h80000001, tbl, 1'b0, e0);
        repeat (27) @(negedge clk);
        check("pre_reset_strobe_high", strobe, 1);
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete(); done_q.delete(); pkt_q.delete();
        check("midreset_strobe", strobe, 0);
        check("midreset_port", port, 0);
        check("midreset_busy", busy, 0);
        check("midreset_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tbl = '{6'h03, 6'h1E, 6'h2B, 6'h1B, 6'h3B, 6'h2F, 6'h00};
        offer(32'hDEADBEEF, tbl, 1'b0, e0);
        wait_idle();

        // Random loopback
        for (int i = 0; i < 100; i++) begin
            rp = $urandom;
            offer(rp, chunks_of(rp), 1'b0, e0);
            wait_idle();
        end

        // Fast timing instance: SETUP=HIGH=HOLD=1, T=3
        tbl = '{6'h02, 6'h25, 6'h0F, 6'h01, 6'h08, 6'h34, 6'h00};
        check("fast_in_ready", f_ready, 1);
        f_pkt = 32'hA53C1234; f_valid = 1'b1;
        fe0 = cyc + 1;
        @(negedge clk);
        f_valid = 1'b0;
        f_pkt = 32'h0;
        fprev = 1'b0; fn = 0; fdone = -1;
        for (int k = 0; k < 7; k++) fgot[k] = 6'h3F;
        for (int i = 0; i < 40; i++) begin
            if (f_strobe && !fprev) begin
                if (fn < 7) fgot[fn] = f_port;
                fn++;
            end
            if (f_done) fdone = cyc;
            fprev = f_strobe;
            @(negedge clk);
        end
        check("fast_rise_count", fn, 7);
        for (int k = 0; k < 7; k++) check("fast_chunk", fgot[k], tbl[k]);
        check("fast_done_cycle", fdone, fe0 + 21);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
